// File: rtl/matvec_pkg.sv
// ----------------------------------------------------------------------------
// matvec_pkg
//  Shared widths, limits and the FIFO word type for the result requantizer.
//  ACC_W       : width of a signed dot-product result from the engine
//  DATA_W      : width of a requantized result (same as engine input_data)
//  VEC_LEN_DEF : default number of results per vector
//  DATA_MAX/MIN: saturation limits of a DATA_W signed value
//  res_word_t  : one buffered result plus its end-of-vector flag
// ----------------------------------------------------------------------------
package matvec_pkg;

    localparam int ACC_W       = 28;
    localparam int DATA_W      = 14;
    localparam int VEC_LEN_DEF = 8;
    localparam int SAT_W       = 8;
    localparam int DATA_MAX    = (1 << (DATA_W - 1)) - 1;
    localparam int DATA_MIN    = -(1 << (DATA_W - 1));

    typedef struct packed {
        logic                     last;
        logic signed [DATA_W-1:0] data;
    } res_word_t;

endpackage

// File: rtl/matvec_result_requant_if.sv
// ----------------------------------------------------------------------------
// matvec_result_requant_if
//  Bundles the result stream from the engine, the requantized output stream,
//  the per-word ReLU enable and the saturation statistics.
//  master : producer/consumer side (engine upstream, next layer downstream)
//  slave  : the requantizer itself
// ----------------------------------------------------------------------------
interface matvec_result_requant_if;
    import matvec_pkg::*;

    // upstream result stream
    logic                     in_valid;
    logic                     in_ready;
    logic signed [ACC_W-1:0]  in_data;
    // configuration / statistics
    logic                     cfg_relu;
    logic                     clear_stats;
    logic [SAT_W-1:0]         sat_count;
    // downstream requantized stream
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;

    modport master (
        output in_valid, in_data, cfg_relu, clear_stats, out_ready,
        input  in_ready, out_valid, out_data, out_last, sat_count
    );

    modport slave (
        input  in_valid, in_data, cfg_relu, clear_stats, out_ready,
        output in_ready, out_valid, out_data, out_last, sat_count
    );

endinterface

// File: rtl/matvec_sync_fifo.sv
// ----------------------------------------------------------------------------
// matvec_sync_fifo
//  Synchronous FIFO of element type T with a registered head word.
//  Ports:
//    clk     : clock, rising edge
//    rst_n   : asynchronous active-low reset (FIFO empty, head cleared)
//    push_i  : write request, qualified internally with ready_o
//    data_i  : write data
//    ready_o : registered "not full"; a pop never frees a slot in the same cycle
//    pop_i   : read request, qualified internally with valid_o
//    valid_o : head word valid (FIFO not empty)
//    data_o  : head word, held until popped
// ----------------------------------------------------------------------------
module matvec_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     data_i,
    output logic ready_o,
    input  logic pop_i,
    output logic valid_o,
    output T     data_o
);

    localparam int AW = $clog2(DEPTH);

    // pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ready_q, full_d;
    logic        do_push, do_pop, head_load;
    T            head_q, head_d;
    T            mem [DEPTH];

    assign valid_o = (wr_ptr_q != rd_ptr_q);
    assign do_push = push_i & ready_q;
    assign do_pop  = pop_i & valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(do_pop);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        // head only moves on a pop or when the first word lands in an empty FIFO
        head_load = do_pop | (do_push & ~valid_o);
        // the incoming word becomes the head directly when it is the next one
        // to be read; otherwise read the array at the next read address
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = data_i;
        end else begin
            head_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ~full_d;
            if (head_load) begin
                head_q <= head_d;
            end
        end
    end

    assign ready_o = ready_q;
    assign data_o  = head_q;

endmodule

// File: rtl/matvec_result_requant.sv
// ----------------------------------------------------------------------------
// matvec_result_requant
//  Requantizes the engine's signed ACC_W-bit dot products to DATA_W-bit signed
//  values (round half up, arithmetic shift by SHIFT, saturate, optional ReLU),
//  tags the last element of every VEC_LEN-long vector and buffers the results
//  in a DEPTH-entry FIFO.
//  Ports:
//    clk   : clock, rising edge
//    reset : asynchronous active-low reset
//    bus   : slave side of matvec_result_requant_if
//            in_valid/in_ready/in_data   result stream in
//            cfg_relu                    clamp negatives to 0, per accepted word
//            clear_stats                 synchronous clear of sat_count
//            out_valid/out_ready/out_data/out_last  requantized stream out
//            sat_count                   saturating count of clipped results
// ----------------------------------------------------------------------------
module matvec_result_requant
    import matvec_pkg::*;
#(
    parameter int SHIFT   = 6,
    parameter int DEPTH   = 8,
    parameter int VEC_LEN = VEC_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    matvec_result_requant_if.slave  bus
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    // rounding constant is half an output LSB; the nested guard keeps the
    // shift amount legal when SHIFT is 0
    localparam int RND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
    localparam logic signed [ACC_W:0] RND_C = (ACC_W + 1)'(RND_INT);
    localparam logic signed [ACC_W:0] HI_C  = (ACC_W + 1)'(DATA_MAX);
    localparam logic signed [ACC_W:0] LO_C  = (ACC_W + 1)'(DATA_MIN);

    logic                     push;
    logic signed [ACC_W:0]    rounded;
    logic signed [ACC_W:0]    shifted;
    logic                     clip_hi, clip_lo;
    logic signed [DATA_W-1:0] res_data;
    res_word_t                wr_word;
    res_word_t                head_word;
    logic [CNT_W-1:0]         elem_q, elem_d;
    logic [SAT_W-1:0]         sat_q, sat_d;

    assign push = bus.in_valid & bus.in_ready;

    // requantization: one extra bit so adding the rounding constant never wraps
    always_comb begin
        rounded = {bus.in_data[ACC_W-1], bus.in_data} + RND_C;
        shifted = rounded >>> SHIFT;
        clip_hi = (shifted > HI_C);
        clip_lo = (shifted < LO_C);
        if (clip_hi) begin
            res_data = DATA_W'(DATA_MAX);
        end else if (clip_lo) begin
            res_data = DATA_W'(DATA_MIN);
        end else begin
            res_data = shifted[DATA_W-1:0];
        end
        // ReLU is applied after saturation and is not a clip
        if (bus.cfg_relu && res_data[DATA_W-1]) begin
            res_data = '0;
        end
        wr_word.last = (elem_q == LAST_IDX);
        wr_word.data = res_data;
    end

    always_comb begin
        elem_d = elem_q;
        if (push) begin
            elem_d = (elem_q == LAST_IDX) ? '0 : elem_q + CNT_W'(1);
        end
        sat_d = sat_q;
        if (bus.clear_stats) begin
            sat_d = '0;
        end else if (push && (clip_hi || clip_lo) && (sat_q != {SAT_W{1'b1}})) begin
            sat_d = sat_q + SAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elem_q <= '0;
            sat_q  <= '0;
        end else begin
            elem_q <= elem_d;
            sat_q  <= sat_d;
        end
    end

    matvec_sync_fifo #(
        .T     (res_word_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .data_i  (wr_word),
        .ready_o (bus.in_ready),
        .pop_i   (bus.out_ready),
        .valid_o (bus.out_valid),
        .data_o  (head_word)
    );

    assign bus.out_data  = head_word.data;
    assign bus.out_last  = head_word.last;
    assign bus.sat_count = sat_q;

endmodule

// File: tb/tb_matvec_result_requant.sv
// ----------------------------------------------------------------------------
// tb_matvec_result_requant
//  Directed bench for matvec_result_requant (SHIFT=6, DEPTH=8, VEC_LEN=8).
//  A queue of expected {last, data} words follows every observed handshake.
// ----------------------------------------------------------------------------
module tb_matvec_result_requant;
    import matvec_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    matvec_result_requant_if bus ();

    matvec_result_requant #(
        .SHIFT   (6),
        .DEPTH   (8),
        .VEC_LEN (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int elem   = 0;
    int n_push = 0;
    int n_pop  = 0;
    logic pushed = 1'b0;
    logic signed [DATA_W-1:0] exp_in = '0;
    res_word_t exp_q [$];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock: score handshakes at the falling edge, return 1 ns after rise
    task automatic tick();
        res_word_t e;
        @(negedge clk);
        pushed = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            n_pop++;
            n_chk++;
            assert (exp_q.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL pop_unexpected: observed queue size %0d expected >0", exp_q.size());
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pop_data", bus.out_data, e.data);
                check("pop_last", bus.out_last, e.last);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e.data = exp_in;
            e.last = (elem == 7);
            exp_q.push_back(e);
            elem   = (elem + 1) % 8;
            n_push++;
            pushed = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int e);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 28'(d);
        exp_in       = 14'(e);
        do begin
            tick();
            guard++;
        end while (!pushed && guard < 50);
        check("push_done", pushed, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int bubbles;
        int p0;
        int sent;
        int guard;

        reset           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.cfg_relu    = 1'b0;
        bus.clear_stats = 1'b0;
        bus.out_ready   = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_sat", bus.sat_count, 0);
        reset = 1'b1;
        tick();
        check("rel_in_ready", bus.in_ready, 1);

        // rounding, first-word latency, head hold
        send(100, 2);
        check("lat_valid", bus.out_valid, 1);
        check("lat_data", bus.out_data, 2);
        send(-100, -2);
        send(31, 0);
        send(32, 1);
        check("hold_data", bus.out_data, 2);
        check("rnd_sat", bus.sat_count, 0);
        drain();

        // ReLU
        bus.cfg_relu = 1'b1;
        send(-100, 0);
        send(100, 2);
        bus.cfg_relu = 1'b0;
        check("relu_sat", bus.sat_count, 0);
        drain();

        // saturation and its edges
        bus.out_ready = 1'b1;
        send(1048576, 8191);
        send(-1048576, -8192);
        check("sat_two", bus.sat_count, 2);
        send(524224, 8191);
        send(-524288, -8192);
        check("sat_edge_noclip", bus.sat_count, 2);
        send(524256, 8191);
        send(-524321, -8192);
        check("sat_edge_clip", bus.sat_count, 4);
        for (int i = 0; i < 300; i++) begin
            send(1048576, 8191);
        end
        check("sat_stick", bus.sat_count, 255);
        bus.clear_stats = 1'b1;
        tick();
        bus.clear_stats = 1'b0;
        check("sat_clear", bus.sat_count, 0);
        bus.clear_stats = 1'b1;
        send(1048576, 8191);
        bus.clear_stats = 1'b0;
        check("sat_clear_wins", bus.sat_count, 0);
        bus.cfg_relu = 1'b1;
        send(-1048576, 0);
        bus.cfg_relu = 1'b0;
        check("sat_relu_clip", bus.sat_count, 1);
        drain();

        // reset mid-stream with three words buffered
        send(64, 1);
        send(128, 2);
        send(192, 3);
        check("pre_rst_valid", bus.out_valid, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_sat", bus.sat_count, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        elem = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        check("mid_rel_in_ready", bus.in_ready, 1);

        // fill to full, no pass-through on pop, order and out_last
        for (int i = 0; i < 8; i++) begin
            send((i + 1) * 64, i + 1);
        end
        check("full_in_ready", bus.in_ready, 0);
        check("full_head", bus.out_data, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 28'(100 * 64);
        exp_in       = 14'(100);
        tick();
        tick();
        check("full_hold_data", bus.out_data, 1);
        check("full_hold_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pop_no_passthru", pushed, 0);
        check("pop_in_ready", bus.in_ready, 1);
        check("pop_next_head", bus.out_data, 2);
        tick();
        bus.in_valid = 1'b0;
        check("refill_push", pushed, 1);
        check("refill_in_ready", bus.in_ready, 0);
        drain();

        // streaming without stalls
        bus.out_ready = 1'b1;
        bubbles = 0;
        p0 = n_pop;
        for (int k = 0; k < 64; k++) begin
            send((k - 32) * 64, k - 32);
            if (!bus.out_valid) bubbles++;
        end
        drain();
        check("stream_bubbles", bubbles, 0);
        check("stream_pops", n_pop - p0, 64);

        // streaming with random output stalls
        sent  = 0;
        guard = 0;
        p0    = n_pop;
        bus.in_valid = 1'b1;
        while (sent < 64 && guard < 2000) begin
            bus.in_data   = 28'((sent * 3 - 90) * 64);
            exp_in        = 14'(sent * 3 - 90);
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
            if (pushed) sent++;
        end
        bus.in_valid = 1'b0;
        check("stall_sent", sent, 64);
        drain();
        check("stall_pops", n_pop - p0, 64);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
